// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and instruction fetch stage with valid/ready handoff to jump resolution
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_address,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               is_jump,
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   jump_count
);
  typedef enum logic [1:0] {ISSUE, CAPTURE, VALID} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] fc_q, fc_d, jc_q, jc_d;
  logic accept;
  // next state; on accept the memory already saw next_pc, so ISSUE is skipped
  always_comb begin
    accept = state_q == VALID && instr_ready;
    state_d = state_q == ISSUE ? CAPTURE : state_q == CAPTURE ? VALID : accept ? CAPTURE : VALID;
    pc_d = accept ? next_pc : pc_q;
    instr_d = state_q == CAPTURE ? imem_rdata : instr_q;
    addr_d = state_q == CAPTURE ? pc_q : addr_q;
    fc_d = fc_q + CNT_W'(accept);
    jc_d = jc_q + CNT_W'(accept & is_jump);
    imem_addr = state_q == VALID ? next_pc : pc_q;
    instr_valid = state_q == VALID;
  end
  // state registers; reset discards any in-flight accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISSUE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      instr_q <= '0;
      fc_q <= '0;
      jc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      fc_q <= fc_d;
      jc_q <= jc_d;
    end
  end
  assign instr = instr_q;
  assign instr_address = addr_q;
  assign fetch_count = fc_q;
  assign jump_count = jc_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the jump-resolution logic. Holds the program counter and reads 16-bit instructions from a synchronous instruction memory. Presents each instruction with its address to the next stage through a valid/ready handshake. Advances the PC to the next-address value returned by the jump-resolution logic, which is `pc + 1` or the branch target.

## Interface
- `ADDR_W`, 12, PC / instruction-memory address width.
- `INSTR_W`, 16, instruction width.
- `RESET_PC`, 12'h000, PC value loaded on reset.
- `CNT_W`, 16, width of the performance counters.

Clock and reset are fixed: one clock, and reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_W  instruction-memory read address; the memory samples it every cycle.
- `imem_rdata`  in  INSTR_W  memory data; valid the cycle after the address is sampled.
- `instr`  out  INSTR_W  registered instruction presented downstream.
- `instr_address`  out  ADDR_W  address of `instr`; equals the PC register.
- `instr_valid`  out  1  `instr` / `instr_address` are valid.
- `instr_ready`  in  1  downstream accepts the instruction this cycle.
- `next_pc`  in  ADDR_W  next fetch address from the jump-resolution logic, computed from `instr` / `instr_address`.
- `is_jump`  in  1  asserted when `next_pc` is a taken-jump target.
- `fetch_count`  out  CNT_W  count of accepted instructions.
- `jump_count`  out  CNT_W  count of accepted instructions with `is_jump` = 1.

## Operation
- FSM states:
  - ISSUE (reset state): `imem_addr` = `pc`; next state is CAPTURE unconditionally.
  - CAPTURE: `instr` <= `imem_rdata`; next state is VALID.
  - VALID: `instr_valid` = 1; `imem_addr` = `next_pc` (combinational).
    - When `instr_ready` = 1, the instruction is accepted: `pc` <= `next_pc`, the next state is CAPTURE, and ISSUE is skipped because the memory already sampled `next_pc` this cycle.
    - When `instr_ready` = 0, the state remains VALID.
- `imem_addr` = `next_pc` in VALID, otherwise `pc`.
- `pc` loads `next_pc` unconditionally on accept. `is_jump` does not select the address; it only feeds `jump_count`.
- On accept, `fetch_count` += 1 and `jump_count` += `is_jump`. Both counters wrap modulo 2^CNT_W.
- Address arithmetic is performed upstream. `next_pc` is taken as-is, so 12'hFFF -> 12'h000 wraps naturally.
- `instr_valid` is 0 in ISSUE and CAPTURE.
- `instr` and `instr_address` change only on the CAPTURE edge, or on reset.
- Reset values on the edge where `reset` = 1:
  - state = ISSUE, `pc` = RESET_PC;
  - `instr` = 0, `instr_valid` = 0;
  - `fetch_count` = 0, `jump_count` = 0;
  - `imem_addr` = RESET_PC, `instr_address` = RESET_PC.
- Reset has priority over the handshake. A reset asserted in any state, including a VALID cycle with `instr_ready` = 1, discards the in-flight instruction. Neither counter increments and `pc` does not load `next_pc`.
- `instr_ready` is ignored outside VALID.

## Timing
- Cycle 0 (first cycle after reset deasserts): ISSUE, memory samples RESET_PC.
- Cycle 1: CAPTURE, `imem_rdata` valid.
- Cycle 2: VALID, `instr` = mem[RESET_PC].
- First-instruction latency: 2 cycles after reset release.
- Steady state with `instr_ready` held high: one instruction per 2 cycles (VALID, CAPTURE alternate).
- Backpressure: VALID is held indefinitely. `instr`, `instr_address`, `pc` and both counters are stable. `imem_addr` tracks `next_pc`, and the memory output is ignored until accept.
- `next_pc` -> `imem_addr` is a combinational path through the jump-resolution logic. No other combinational input-to-output paths exist.

## Test plan
- Reset release with mem[0] = 16'h1234 and `instr_ready` = 1 -> `imem_addr` = 0 in cycles 0–1; cycle 2: `instr_valid` = 1, `instr` = 16'h1234, `instr_address` = 0.
- Sequential stream with `next_pc` = `instr_address` + 1, `is_jump` = 0 and ready high -> `instr_address` 0, 1, 2, 3 valid every 2nd cycle; after 4 accepts `fetch_count` = 4 and `jump_count` = 0.
- Backpressure: `instr_ready` = 0 for 5 cycles at `instr_address` = 2 -> all outputs and counters stable. On the cycle ready rises, accept occurs and `instr_address` = 3 appears 2 cycles later.
- Taken jump: at `instr_address` = 12'h010 drive `next_pc` = 12'h00C and `is_jump` = 1, with mem[12'h00C] = 16'hA55A -> next valid `instr_address` = 12'h00C, `instr` = 16'hA55A, `jump_count` = 1.
- Wrap-around: `instr_address` = 12'hFFF with `next_pc` = 12'h000 -> next valid `instr_address` = 12'h000 and `instr` = mem[0].
- Reset asserted for one cycle while in VALID with `instr_ready` = 1 -> counters stay 0 with no increment; `instr_valid` = 0 next cycle; `pc` = RESET_PC; the first instruction is re-fetched 2 cycles after release.
